mont_mult: RTL and testbench
============================

Name: mont_mult

Overview:
- Radix-2 bit-serial Montgomery multiplier: computes x_out = A·B·R⁻¹ mod N with R = 2^WIDTH.
- Sits directly upstream of mont_reduction in the modular-exponentiation datapath. It converts operands into Montgomery form (B = R² mod N) and performs every square/multiply step.
- Its x_out feeds mont_reduction's x_mont.
- No N_prime needed: the radix-2 odd/even correction uses N directly.

Parameters:
- WIDTH, 512, operand/modulus width in bits. R = 2^WIDTH.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- a_in  input  WIDTH  multiplicand A, requires A < N
- b_in  input  WIDTH  multiplier B, requires B < N
- N  input  WIDTH  odd modulus, MSB set not required
- valid_in  input  1  start pulse; operands sampled this cycle
- x_out  output  WIDTH  result A·B·R⁻¹ mod N; held until next result
- valid_out  output  1  one-cycle pulse, x_out valid
- busy_out  output  1  high while an operation is in flight

Behaviour:
- One clock (clk_in); reset is synchronous, active-high (rst_in), sampled on the rising edge.
- Reset state: state = IDLE, x_out = 0, valid_out = 0, busy_out = 0, accumulator S = 0, bit counter = 0.
- States:
  - IDLE: on valid_in, latch A, B, N into registers, clear S to 0 and the counter to 0, set busy_out. Next state is LOOP.
  - LOOP: one iteration per cycle, i = 0..WIDTH-1, using A bit i (LSB first, by shift register or index).
    - T = S + (a_i ? B : 0)
    - if T[0], T = T + N
    - S = T >> 1
    - After iteration WIDTH-1, go to FINAL.
  - FINAL: if S ≥ N, x_out = S − N; else x_out = S. Assert valid_out for one cycle, clear busy_out, return to IDLE.
- Widths:
  - S is WIDTH+1 bits; T is WIDTH+2 bits, so no overflow occurs.
  - The invariant S < 2N holds, so one conditional subtract suffices.
  - x_out is truncated to WIDTH bits after the subtract.
- Latency: valid_in sampled at edge k; valid_out is high in the cycle after edge k+WIDTH+1, i.e. exactly WIDTH+2 cycles between valid_in and valid_out. This latency is fixed and independent of the data.
- busy_out goes high the cycle after valid_in is accepted and stays high through FINAL. It is low in the same cycle valid_out is high.
- valid_in while busy_out = 1: ignored, with no effect on the operation in flight.
- valid_in in the same cycle valid_out pulses (state FINAL→IDLE): ignored. Accepted only from IDLE.
- Input ports may change after acceptance; internal copies are used.
- rst_in mid-operation: abort immediately, go to IDLE, apply reset values. No valid_out is produced for the aborted job.
- A = 0 or B = 0 yields 0.
- Even N, or A/B ≥ N: undefined result unless the optional feature is enabled. Latency is unchanged.

Optional Feature:
- Macro: MONT_MULT_CHECK_EN.
- Defined:
  - Adds output err_out (1 bit, reset 0).
  - At acceptance, if N[0] = 0, a_in ≥ N, or b_in ≥ N, the block skips LOOP/FINAL.
  - Next cycle: valid_out = 1, err_out = 1, x_out = 0. err_out is a one-cycle pulse coincident with valid_out.
  - Valid operations keep err_out = 0 and normal latency.
- Undefined: no err_out port and no input checks. Behaviour is as above.

Decomposition:
- Shared package mont_pkg:
  - state enum type (IDLE, LOOP, FINAL)
  - default WIDTH localparam (512), shared with mont_reduction
- One natural sub-module: mont_mult_step, a combinational single iteration. Inputs S, a_i, B, N; output next S.
- mont_mult_step is instantiated once in LOOP. It is unit-testable on its own.

Test Plan:
All scenarios use WIDTH=16 (R=65536) and N=33227 unless noted.
- A=46, B=12049 (R² mod N) → x_out=24226 (46·R mod N). valid_out exactly 18 cycles after valid_in; busy_out high 17 cycles.
- A=1, B=32309 (R mod N) → x_out=1. A=33226 (N−1), B=32309 → x_out=33226. A=0, B=12049 → x_out=0.
- Chain: feed x_out=24226 into mont_reduction (WIDTH=16, N_prime=39907) → 46.
- Second valid_in with A=5, B=7 asserted mid-LOOP → ignored; first result 24226 unchanged, no extra valid_out.
- rst_in pulsed 5 cycles into an operation → no valid_out, x_out=0. A fresh start afterwards returns the correct result at normal latency.
- With MONT_MULT_CHECK_EN defined:
  - N=33226 (even) → valid_out and err_out high the cycle after acceptance, x_out=0.
  - A=40000 ≥ N → same error response.
  - A=46, B=12049 → err_out=0, x_out=24226.
- WIDTH=512: random A, B < N against a reference model, latency 514 cycles.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared Montgomery datapath definitions: FSM state type and default width.
// Used by mont_mult, mont_mult_step and mont_reduction.
package mont_pkg;

    localparam int DEF_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOOP  = 2'd1,
        FINAL = 2'd2
    } mont_state_e;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mont_mult_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_i*B [+ N if odd]) / 2.
// Ports: s_i (WIDTH+1), a_i, b_i, n_i -> s_o (WIDTH+1). Purely combinational.
import mont_pkg::*;

module mont_mult_step #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   s_i,
    input  logic             a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH:0]   s_o
);

    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_odd;

    always_comb begin
        t_add = {1'b0, s_i} + (a_i ? {2'b00, b_i} : '0);
        // Adding odd N makes T even, so the shift below is exact.
        t_odd = t_add[0] ? (t_add + {2'b00, n_i}) : t_add;
        s_o   = (WIDTH + 1)'(t_odd >> 1);
    end

endmodule

// File: rtl/mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: x_out = A*B*R^-1 mod N, R = 2^WIDTH.
// Ports: clk_in, rst_in (sync, active-high), a_in, b_in, N, valid_in ->
//   x_out, valid_out (1-cycle pulse), busy_out; err_out when MONT_MULT_CHECK_EN.
// Latency WIDTH+2 cycles from valid_in to valid_out.
import mont_pkg::*;

module mont_mult #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] N,
    input  logic             valid_in,
    output logic [WIDTH-1:0] x_out,
    output logic             valid_out,
    output logic             busy_out
`ifdef MONT_MULT_CHECK_EN
    ,
    output logic             err_out
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mont_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH:0]   s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   s_next;

`ifdef MONT_MULT_CHECK_EN
    logic             err_q, err_d;
    logic             bad_in;

    assign bad_in  = ~N[0] | (a_in >= N) | (b_in >= N);
    assign err_out = err_q;
`endif

    // A is consumed LSB first out of a_q, which shifts right each step.
    mont_mult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .s_i(s_q),
        .a_i(a_q[0]),
        .b_i(b_q),
        .n_i(n_q),
        .s_o(s_next)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MONT_MULT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
`ifdef MONT_MULT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        vld_d   = 1'b0;
        busy_d  = busy_q;
`ifdef MONT_MULT_CHECK_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
`ifdef MONT_MULT_CHECK_EN
                    if (bad_in) begin
                        x_d   = '0;
                        vld_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
`endif
                        a_d     = a_in;
                        b_d     = b_in;
                        n_d     = N;
                        s_d     = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = LOOP;
`ifdef MONT_MULT_CHECK_EN
                    end
`endif
                end
            end
            LOOP: begin
                s_d   = s_next;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                // S < 2N, so a single conditional subtract fully reduces.
                if (s_q >= {1'b0, n_q}) begin
                    x_d = WIDTH'(s_q - {1'b0, n_q});
                end else begin
                    x_d = s_q[WIDTH-1:0];
                end
                vld_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign x_out     = x_q;
    assign valid_out = vld_q;
    assign busy_out  = busy_q;

endmodule

// File: tb/tb_mont_mult.sv
// Directed self-checking bench for mont_mult at WIDTH=16, N=33227.
// Covers table vectors, latency/busy timing, ignored restart, mid-op reset.
module tb_mont_mult;

    localparam int W = 16;
    localparam logic [W-1:0] NMOD = 16'd33227;

    logic         clk;
    logic         rst_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] n_in;
    logic         valid_in;
    logic [W-1:0] x_out;
    logic         valid_out;
    logic         busy_out;
    logic         err_w;

    int errors = 0;
    int checks = 0;

    mont_mult #(
        .WIDTH(W)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .N        (n_in),
        .valid_in (valid_in),
        .x_out    (x_out),
        .valid_out(valid_out),
        .busy_out (busy_out)
`ifdef MONT_MULT_CHECK_EN
        ,
        .err_out  (err_w)
`endif
    );

`ifndef MONT_MULT_CHECK_EN
    assign err_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] x;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one job and observes 60 cycles. Inputs are scrambled after
    // acceptance; inj injects a (5,7) start mid-run, rst_at pulses reset.
    task automatic run_op(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic [W-1:0] n,
        input  int           inj,
        input  int           rst_at,
        output logic [W-1:0] x,
        output int           lat,
        output int           bcnt,
        output int           vcnt,
        output logic         err
    );
        lat  = 0;
        bcnt = 0;
        vcnt = 0;
        x    = '0;
        err  = 1'b0;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        n_in     = n;
        valid_in = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            valid_in = 1'b0;
            rst_in   = 1'b0;
            a_in     = ~a;
            b_in     = b ^ 16'h5a5a;
            n_in     = n ^ 16'h0f00;
            if (busy_out) bcnt++;
            if (valid_out) begin
                vcnt++;
                if (lat == 0) begin
                    lat = c;
                    x   = x_out;
                    err = err_w;
                end
            end
            if (c == inj) begin
                valid_in = 1'b1;
                a_in     = 16'd5;
                b_in     = 16'd7;
            end
            if (c == rst_at) rst_in = 1'b1;
        end
    endtask

    logic [W-1:0] x;
    int           lat;
    int           bcnt;
    int           vcnt;
    logic         err;

    initial begin
        vecs[0] = '{a: 16'd46,    b: 16'd12049, x: 16'd24226};
        vecs[1] = '{a: 16'd1,     b: 16'd32309, x: 16'd1};
        vecs[2] = '{a: 16'd33226, b: 16'd32309, x: 16'd33226};
        vecs[3] = '{a: 16'd0,     b: 16'd12049, x: 16'd0};
        vecs[4] = '{a: 16'd24226, b: 16'd1,     x: 16'd46};
        vecs[5] = '{a: 16'd32309, b: 16'd32309, x: 16'd32309};
        vecs[6] = '{a: 16'd12049, b: 16'd1,     x: 16'd32309};
        vecs[7] = '{a: 16'd24226, b: 16'd24226, x: 16'd17905};
        vecs[8] = '{a: 16'd5,     b: 16'd0,     x: 16'd0};

        rst_in   = 1'b1;
        valid_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        n_in     = NMOD;
        repeat (3) @(negedge clk);
        chk("reset x_out", int'(x_out), 0);
        chk("reset valid_out", int'(valid_out), 0);
        chk("reset busy_out", int'(busy_out), 0);
        rst_in = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, NMOD, 0, 0, x, lat, bcnt, vcnt, err);
            chk($sformatf("vec%0d x_out", i), int'(x), int'(vecs[i].x));
            chk($sformatf("vec%0d latency", i), lat, W + 2);
            chk($sformatf("vec%0d busy cycles", i), bcnt, W + 1);
            chk($sformatf("vec%0d valid pulses", i), vcnt, 1);
`ifdef MONT_MULT_CHECK_EN
            chk($sformatf("vec%0d err_out", i), int'(err), 0);
`endif
        end

        // Restart attempt mid-LOOP must be ignored.
        run_op(16'd46, 16'd12049, NMOD, 6, 0, x, lat, bcnt, vcnt, err);
        chk("ignored start x_out", int'(x), 24226);
        chk("ignored start latency", lat, W + 2);
        chk("ignored start pulses", vcnt, 1);

        // Reset 5 cycles into a job aborts it.
        run_op(16'd46, 16'd12049, NMOD, 0, 5, x, lat, bcnt, vcnt, err);
        chk("abort valid pulses", vcnt, 0);
        chk("abort x_out", int'(x_out), 0);
        chk("abort busy_out", int'(busy_out), 0);

        run_op(16'd1, 16'd32309, NMOD, 0, 0, x, lat, bcnt, vcnt, err);
        chk("post-abort x_out", int'(x), 1);
        chk("post-abort latency", lat, W + 2);

`ifdef MONT_MULT_CHECK_EN
        run_op(16'd46, 16'd12049, 16'd33226, 0, 0, x, lat, bcnt, vcnt, err);
        chk("even N latency", lat, 1);
        chk("even N err_out", int'(err), 1);
        chk("even N x_out", int'(x), 0);
        chk("even N busy", bcnt, 0);

        run_op(16'd40000, 16'd12049, NMOD, 0, 0, x, lat, bcnt, vcnt, err);
        chk("A>=N latency", lat, 1);
        chk("A>=N err_out", int'(err), 1);
        chk("A>=N x_out", int'(x), 0);

        run_op(16'd46, 16'd12049, NMOD, 0, 0, x, lat, bcnt, vcnt, err);
        chk("check ok err_out", int'(err), 0);
        chk("check ok x_out", int'(x), 24226);
        chk("check ok latency", lat, W + 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
